// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO on a register-array memory: pointers, occupancy count,
// full/empty and programmable almost flags, registered read data, sticky errors.
module sync_fifo_mem #(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = 4,
    parameter int AFULL_LVL  = (1 << ADDRSIZE) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    input  logic                clr_err,
    output logic [DATASIZE-1:0] rdata,
    output logic                wfull,
    output logic                walmost_full,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0]   C_DEPTH  = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0]   C_AFULL  = (ADDRSIZE+1)'(AFULL_LVL);
    localparam logic [ADDRSIZE:0]   C_AEMPTY = (ADDRSIZE+1)'(AEMPTY_LVL);
    localparam logic [ADDRSIZE:0]   C_CNT1   = 1;
    localparam logic [ADDRSIZE-1:0] C_PTR1   = 1;

    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [ADDRSIZE-1:0] r_waddr;
    logic [ADDRSIZE-1:0] r_raddr;
    logic [ADDRSIZE:0]   r_count;
    logic [DATASIZE-1:0] r_rdata;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_full;
    logic                w_empty;
    logic                w_we;
    logic                w_re;

    // Flags decode the registered count only, so no request reaches a flag combinationally.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_we    = winc && !w_full;
    assign w_re    = rinc && !w_empty;

    // Memory is not reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (w_we && rst_n) begin
            r_mem[r_waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr <= '0;
            r_raddr <= '0;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            if (w_we) begin
                r_waddr <= r_waddr + C_PTR1;
            end
            if (w_re) begin
                r_raddr <= r_raddr + C_PTR1;
                r_rdata <= r_mem[r_raddr];
            end
            case ({w_we, w_re})
                2'b10:   r_count <= r_count + C_CNT1;
                2'b01:   r_count <= r_count - C_CNT1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Error capture: a new error in the same cycle as clr_err keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rinc && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign rdata         = r_rdata;
    assign count         = r_count;
    assign wfull         = w_full;
    assign rempty        = w_empty;
    assign walmost_full  = (r_count >= C_AFULL);
    assign ralmost_empty = (r_count <= C_AEMPTY);
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;
endmodule

// File: tb/tb_sync_fifo_mem.sv
// Bench for sync_fifo_mem: a fixed vector table with hand-derived expectations,
// then queue-scoreboard sequences for fill/drain, wrap, collisions and reset.
module tb_sync_fifo_mem;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       winc = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rinc = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rdata;
    logic       wfull, walmost_full, rempty, ralmost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    sync_fifo_mem #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2)) dut (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
        .clr_err(clr_err), .rdata(rdata), .wfull(wfull), .walmost_full(walmost_full),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic [7:0] m_rdata = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       c;
        logic [4:0] cnt;
        logic [7:0] rd;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       udf;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, "_count"}, 32'(count), 32'(sz));
        chk({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
        chk({tag, "_wfull"}, 32'(wfull), 32'(sz == 16));
        chk({tag, "_walmost_full"}, 32'(walmost_full), 32'(sz >= 14));
        chk({tag, "_rempty"}, 32'(rempty), 32'(sz == 0));
        chk({tag, "_ralmost_empty"}, 32'(ralmost_empty), 32'(sz <= 2));
        chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    // One clock of stimulus; the model predicts the state after the edge.
    task automatic step(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        logic full_now, empty_now;
        full_now  = (q.size() == 16);
        empty_now = (q.size() == 0);
        winc = w; wdata = d; rinc = r; clr_err = c;
        if (r && !empty_now) m_rdata = q.pop_front();
        if (w && !full_now) q.push_back(d);
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (w && full_now) m_ovf = 1'b1;
        if (r && empty_now) m_udf = 1'b1;
        @(posedge clk);
        #1;
        check_all(tag);
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all({tag, "_async"});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all({tag, "_rel"});
    endtask

    initial begin
        //            w     d      r     c     cnt    rdata  emp   ful   ovf   udf
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h7E, 1'b1, 1'b0, 5'd2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 5'd1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset("reset0");

        for (int i = 0; i < 9; i++) begin
            winc = tbl[i].w; wdata = tbl[i].d; rinc = tbl[i].r; clr_err = tbl[i].c;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_rempty", i), 32'(rempty), 32'(tbl[i].emp));
            chk($sformatf("tbl%0d_wfull", i), 32'(wfull), 32'(tbl[i].ful));
            chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].udf));
            winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
        end

        do_reset("reset1");

        // Fill 0x00..0x0F, then one write too many.
        for (int i = 0; i < 16; i++) step($sformatf("fill%0d", i), 1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_count16", 32'(count), 32'd16);
        step("fill_over", 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("over_flag", 32'(overflow), 32'd1);
        step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf_flag", 32'(overflow), 32'd0);
        step("clr_vs_set", 1'b1, 8'h99, 1'b0, 1'b1);
        chk("set_wins_ovf", 32'(overflow), 32'd1);
        step("clr_ovf2", 1'b0, 8'h00, 1'b0, 1'b1);

        // Drain all 16 and one read too many.
        for (int i = 0; i < 16; i++) step($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);
        step("drain_under", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("under_rdata_hold", 32'(rdata), 32'h0F);
        chk("under_flag", 32'(underflow), 32'd1);
        step("clr_udf", 1'b0, 8'h00, 1'b0, 1'b1);

        // Hold count at 8 while streaming across two pointer wraps.
        for (int i = 0; i < 8; i++) step($sformatf("pre%0d", i), 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step($sformatf("stream%0d", i), 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        chk("stream_count8", 32'(count), 32'd8);

        // Full with both requests: read wins, write dropped.
        for (int i = 0; i < 8; i++) step($sformatf("top%0d", i), 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step("full_both", 1'b1, 8'hDD, 1'b1, 1'b0);
        chk("full_both_count", 32'(count), 32'd15);
        chk("full_both_ovf", 32'(overflow), 32'd1);
        step("clr3", 1'b0, 8'h00, 1'b0, 1'b1);

        // Empty with both requests: write accepted, read dropped.
        for (int i = 0; i < 15; i++) step($sformatf("empt%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);
        step("empty_both", 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("empty_both_count", 32'(count), 32'd1);
        chk("empty_both_udf", 32'(underflow), 32'd1);
        step("empty_both_rd", 1'b0, 8'h00, 1'b1, 1'b1);
        chk("empty_both_data", 32'(rdata), 32'h5A);

        // Asynchronous reset mid-stream at count 5 with a write in flight.
        for (int i = 0; i < 5; i++) step($sformatf("mid%0d", i), 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        #2;
        winc = 1'b1; wdata = 8'hF0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midrst_async");
        @(posedge clk);
        #1;
        check_all("midrst_held");
        winc = 1'b0;
        rst_n = 1'b1;
        step("post_w", 1'b1, 8'hAB, 1'b0, 1'b0);
        step("post_w2", 1'b1, 8'hCD, 1'b0, 1'b0);
        step("post_r", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_first", 32'(rdata), 32'hAB);
        step("post_r2", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
